ifid_queue: RTL and testbench
=============================

# ifid_queue

Parametrised IF→ID boundary buffer that replaces the single-entry IF/ID register with a DEPTH-entry first-word-fall-through queue. It captures each fetched instruction with its PC, branch-delay-slot flag and optional fetch exception, and presents the oldest entry to the decode stage. Decode stalls are absorbed without back-pressuring fetch until the queue is full. A NOP bubble is injected when the queue is empty or flushed.

## Interface
- DATA_W, 32, width of instruction and PC fields
- DEPTH, 2, entry count; power of two, ≥2
- clock  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- IF_Valid  in  1  fetch presents a valid word this cycle
- IF_Ready  out  1  queue can accept a word (count ≠ DEPTH)
- IF_Instruction  in  DATA_W  fetched instruction
- IF_PCOut  in  DATA_W  PC of fetched instruction
- IF_IsBDS  in  1  fetched word is a branch delay slot
- IF_EXC_AdIF  in  1  fetch address error (IFID_EXC_EN only)
- IF_Flush  in  1  discard all held and incoming entries
- ID_Stall  in  1  decode does not consume this cycle
- ID_Valid  out  1  head entry valid
- ID_Instruction  out  DATA_W  head instruction; 0 (NOP) when !ID_Valid
- ID_PCAdd4  out  DATA_W  head PC + 4
- ID_RestartPC  out  DATA_W  exception restart PC of head
- ID_IsBDS  out  1  head is a delay slot
- ID_EXC_AdIF  out  1  head carries AdIF (IFID_EXC_EN only)
- Count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- push = IF_Valid & IF_Ready & ~IF_Flush; pop = ID_Valid & ~ID_Stall.
- Storage: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH naturally; Count tracked separately.
- push only: write at wr_ptr, wr_ptr+1, Count+1. pop only: rd_ptr+1, Count−1. push & pop: both pointers advance, Count unchanged. Push is impossible when full, so there is no overflow. Pop is impossible when empty, so there is no underflow.
- IF_Ready depends only on Count. There is no combinational path from ID_Stall.
- ID_Valid = (Count ≠ 0) & ~IF_Flush. When !ID_Valid, ID_Instruction = 0, ID_IsBDS = 0 and ID_EXC_AdIF = 0. PC outputs are don't-care.
- Flush: next edge sets Count = 0 and both pointers to 0. Flush overrides a simultaneous push and pop.
- ID_PCAdd4 = head PC + 4, modulo 2^DATA_W.
- ID_RestartPC = head IsBDS ? head PC − 4 : head PC, modulo 2^DATA_W. A delay-slot exception restarts at the branch.
- Reset (asserted at any time, including mid-stream): Count = 0, pointers = 0, ID_Valid = 0, ID_Instruction = 0, IF_Ready = 1. Storage contents are not reset.

## Timing
- Latency: a word pushed at edge N is at the head after edge N when the queue was empty. Decode sees it in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- A full queue with pop in cycle N shows IF_Ready = 1 only after edge N. Full throughput at full occupancy therefore needs DEPTH ≥ 2.
- Flush in cycle N: ID_Valid = 0 in cycle N (combinational gating). The queue is empty from cycle N+1, and IF_Ready = 1 in N+1.
- All state registers are on posedge clock or negedge reset_n.

## Configuration
- IFID_EXC_EN defined: IF_EXC_AdIF and ID_EXC_AdIF ports exist. The AdIF bit is stored per entry. An entry pushed with AdIF = 1 stores instruction 0 (NOP) regardless of IF_Instruction.
- IFID_EXC_EN undefined: both ports and the storage bit are absent. All other behaviour is identical.

## Structure
- Package ifid_pkg: typedef fetch_entry_t, a packed struct of instr, pc, is_bds and, under IFID_EXC_EN, exc_adif. It also holds the constant NOP_INSTR = 32'h0000_0000. The package is parametrised via DATA_W = 32 localparam.
- Sub-module ifid_ptr_ctrl holds the pointers, Count, full/empty and flush logic. The top level holds the entry array and output muxing.

## Test plan
- Reset then push 0x2408_0005 at PC 0x0040_0000 → after one edge: ID_Valid = 1, ID_PCAdd4 = 0x0040_0004, Count = 1.
- Hold ID_Stall and push DEPTH words → Count = DEPTH, IF_Ready = 0. A further IF_Valid is ignored, and the head is still the first word.
- Full queue, release ID_Stall while pushing continuously for 4·DEPTH cycles → words emerge in order across pointer wrap, with no loss or duplication.
- Queue holding 2 entries, IF_Flush with simultaneous push and pop → ID_Valid = 0 that cycle, then Count = 0. The pushed word never appears.
- Push with IF_IsBDS = 1 at PC 0x0040_0104 → ID_RestartPC = 0x0040_0100. With IFID_EXC_EN and AdIF = 1, ID_Instruction = 0 and ID_EXC_AdIF = 1.
- Assert reset_n low mid-stream between clock edges → outputs reach reset values immediately; the first push after release becomes the head.

Source files
------------

// File: rtl/ifid_queue_pkg.sv
// ifid_pkg: fetch entry type, NOP constant and restart-PC helper for the IF/ID queue.
// Optional macro IFID_EXC_EN adds the per-entry fetch address error bit.
`default_nettype none

package ifid_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic              is_bds;
`ifdef IFID_EXC_EN
    logic              exc_adif;
`endif
  } fetch_entry_t;

  // A delay slot that faults must restart at its branch, one word earlier.
  function automatic logic [DATA_W-1:0] restart_pc(input logic [DATA_W-1:0] pc,
                                                   input logic              is_bds);
    return is_bds ? (pc - DATA_W'(4)) : pc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifid_queue_if.sv
// ifid_queue_if: fetch-side and decode-side signals of the IF/ID queue.
// Optional macro IFID_EXC_EN adds IF_EXC_AdIF / ID_EXC_AdIF.
`default_nettype none

interface ifid_queue_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              IF_Valid;
  logic              IF_Ready;
  logic [DATA_W-1:0] IF_Instruction;
  logic [DATA_W-1:0] IF_PCOut;
  logic              IF_IsBDS;
  logic              IF_Flush;
  logic              ID_Stall;
  logic              ID_Valid;
  logic [DATA_W-1:0] ID_Instruction;
  logic [DATA_W-1:0] ID_PCAdd4;
  logic [DATA_W-1:0] ID_RestartPC;
  logic              ID_IsBDS;
  logic [CNT_W-1:0]  Count;
`ifdef IFID_EXC_EN
  logic              IF_EXC_AdIF;
  logic              ID_EXC_AdIF;
`endif

  modport slave (
`ifdef IFID_EXC_EN
    input  IF_EXC_AdIF,
    output ID_EXC_AdIF,
`endif
    input  IF_Valid,
    input  IF_Instruction,
    input  IF_PCOut,
    input  IF_IsBDS,
    input  IF_Flush,
    input  ID_Stall,
    output IF_Ready,
    output ID_Valid,
    output ID_Instruction,
    output ID_PCAdd4,
    output ID_RestartPC,
    output ID_IsBDS,
    output Count
  );

  modport master (
`ifdef IFID_EXC_EN
    output IF_EXC_AdIF,
    input  ID_EXC_AdIF,
`endif
    output IF_Valid,
    output IF_Instruction,
    output IF_PCOut,
    output IF_IsBDS,
    output IF_Flush,
    output ID_Stall,
    input  IF_Ready,
    input  ID_Valid,
    input  ID_Instruction,
    input  ID_PCAdd4,
    input  ID_RestartPC,
    input  ID_IsBDS,
    input  Count
  );

endinterface

`default_nettype wire

// File: rtl/ifid_queue_ptr_ctrl.sv
// ifid_ptr_ctrl: read/write pointers, occupancy count, push/pop qualification and flush.
`default_nettype none

module ifid_ptr_ctrl #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             if_valid,
  input  logic             if_flush,
  input  logic             id_stall,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             if_ready,
  output logic             id_valid,
  output logic             push
);

  logic pop;
  logic full;
  logic empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Ready is a function of stored occupancy only, so stall never reaches fetch combinationally.
  assign if_ready = ~full;
  assign id_valid = ~empty & ~if_flush;
  assign push     = if_valid & if_ready & ~if_flush;
  assign pop      = id_valid & ~id_stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (if_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifid_queue.sv
// ifid_queue: DEPTH-entry first-word-fall-through IF/ID buffer with NOP bubble on empty/flush.
// Optional macro IFID_EXC_EN stores a fetch address error bit per entry and forces its word to NOP.
`default_nettype none

module ifid_queue
  import ifid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  ifid_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             if_ready;
  logic             id_valid;
  logic             push;

  fetch_entry_t     entries [DEPTH];
  fetch_entry_t     new_entry;
  fetch_entry_t     head;

  ifid_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ptr_ctrl (
    .clock    (clock),
    .reset_n  (reset_n),
    .if_valid (bus.IF_Valid),
    .if_flush (bus.IF_Flush),
    .id_stall (bus.ID_Stall),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .if_ready (if_ready),
    .id_valid (id_valid),
    .push     (push)
  );

  always_comb begin
    new_entry        = '0;
    new_entry.instr  = bus.IF_Instruction;
    new_entry.pc     = bus.IF_PCOut;
    new_entry.is_bds = bus.IF_IsBDS;
`ifdef IFID_EXC_EN
    new_entry.exc_adif = bus.IF_EXC_AdIF;
    // A faulting fetch carries no usable word; decode sees a NOP plus the exception flag.
    if (bus.IF_EXC_AdIF) begin
      new_entry.instr = NOP_INSTR;
    end
`endif
  end

  // Entry storage is deliberately left out of reset; validity comes from count alone.
  always_ff @(posedge clock) begin
    if (push) begin
      entries[wr_ptr] <= new_entry;
    end
  end

  assign head = entries[rd_ptr];

  assign bus.IF_Ready       = if_ready;
  assign bus.ID_Valid       = id_valid;
  assign bus.Count          = count;
  assign bus.ID_Instruction = id_valid ? head.instr : NOP_INSTR;
  assign bus.ID_IsBDS       = id_valid & head.is_bds;
  assign bus.ID_PCAdd4      = head.pc + DATA_W'(4);
  assign bus.ID_RestartPC   = restart_pc(head.pc, head.is_bds);
`ifdef IFID_EXC_EN
  assign bus.ID_EXC_AdIF    = id_valid & head.exc_adif;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: randomized and directed stimulus checked against a queue-based reference model.
`default_nettype none

module tb_ifid_queue;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bds;
    logic        adif;
  } ent_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  ent_t q[$];

  logic        d_v;
  logic [31:0] d_ins;
  logic [31:0] d_pc;
  logic        d_bds;
  logic        d_adif;
  logic        d_fl;
  logic        d_st;

  ifid_queue_if #(.DATA_W(32), .DEPTH(DEPTH)) bus ();

  ifid_queue #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic get_adif();
`ifdef IFID_EXC_EN
    return bus.ID_EXC_AdIF;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_check();
    ent_t        h;
    logic [31:0] e_add4;
    logic [31:0] e_rst;
    logic        e_valid;
    e_valid = (q.size() != 0) && !d_fl;
    chk("ready", bus.IF_Ready, (q.size() != DEPTH));
    chk("valid", bus.ID_Valid, e_valid);
    chk("count", bus.Count, q.size());
    if (e_valid) begin
      h      = q[0];
      e_add4 = h.pc + 32'd4;
      e_rst  = h.bds ? (h.pc - 32'd4) : h.pc;
      chk("instr", bus.ID_Instruction, h.adif ? 32'h0 : h.instr);
      chk("pcadd4", bus.ID_PCAdd4, e_add4);
      chk("restart", bus.ID_RestartPC, e_rst);
      chk("bds", bus.ID_IsBDS, h.bds);
      chk("adif", get_adif(), h.adif);
    end else begin
      chk("bubble_instr", bus.ID_Instruction, 32'h0);
      chk("bubble_bds", bus.ID_IsBDS, 1'b0);
      chk("bubble_adif", get_adif(), 1'b0);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic bds, input logic adif, input logic fl, input logic st);
    @(negedge clk);
    d_v  = v;  d_ins = ins; d_pc = pc; d_bds = bds; d_fl = fl; d_st = st;
`ifdef IFID_EXC_EN
    d_adif = adif;
    bus.IF_EXC_AdIF = adif;
`else
    d_adif = 1'b0;
    if (adif) d_adif = 1'b0;
`endif
    bus.IF_Valid = v; bus.IF_Instruction = ins; bus.IF_PCOut = pc;
    bus.IF_IsBDS = bds; bus.IF_Flush = fl; bus.ID_Stall = st;
    #1;
    model_check();
  endtask

  task automatic tick();
    ent_t e;
    logic push;
    logic pop;
    @(posedge clk);
    push = d_v && (q.size() != DEPTH) && !d_fl;
    pop  = (q.size() != 0) && !d_fl && !d_st;
    if (d_fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.instr = d_ins; e.pc = d_pc; e.bds = d_bds; e.adif = d_adif;
        q.push_back(e);
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic bds, input logic adif, input logic fl, input logic st);
    drive(v, ins, pc, bds, adif, fl, st);
    tick();
  endtask

  initial begin
    logic [31:0] r_ins;
    logic [31:0] r_pc;
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    d_v = 0; d_ins = 0; d_pc = 0; d_bds = 0; d_adif = 0; d_fl = 0; d_st = 1;
    bus.IF_Valid = 0; bus.IF_Instruction = 0; bus.IF_PCOut = 0;
    bus.IF_IsBDS = 0; bus.IF_Flush = 0; bus.ID_Stall = 1;
`ifdef IFID_EXC_EN
    bus.IF_EXC_AdIF = 0;
`endif
    #12;
    chk("rst_count", bus.Count, 0);
    chk("rst_valid", bus.ID_Valid, 0);
    chk("rst_instr", bus.ID_Instruction, 32'h0);
    chk("rst_ready", bus.IF_Ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // First word, visible after one edge.
    step(1, 32'h2408_0005, 32'h0040_0000, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("first_valid", bus.ID_Valid, 1);
    chk("first_pcadd4", bus.ID_PCAdd4, 32'h0040_0004);
    chk("first_count", bus.Count, 1);
    tick();

    // Fill under stall, then an extra push must be ignored.
    step(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < DEPTH; i++)
      step(1, 32'h1000_0000 + i, 32'h0000_1000 + 4 * i, 0, 0, 0, 1);
    drive(1, 32'hBAD0_0000, 32'h0000_2000, 0, 0, 0, 1);
    chk("full_ready", bus.IF_Ready, 0);
    chk("full_count", bus.Count, DEPTH);
    chk("full_head", bus.ID_Instruction, 32'h1000_0000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("full_head_kept", bus.ID_Instruction, 32'h1000_0000);
    tick();

    // Streaming across pointer wrap.
    for (int i = 0; i < 4 * DEPTH; i++)
      step(1, 32'h2000_0000 + i, 32'h0000_3000 + 4 * i, 0, 0, 0, 0);

    // Flush with simultaneous push and pop while holding two entries.
    step(0, 0, 0, 0, 0, 1, 1);
    step(1, 32'h3000_0001, 32'h0000_4000, 0, 0, 0, 1);
    step(1, 32'h3000_0002, 32'h0000_4004, 0, 0, 0, 1);
    drive(1, 32'h3000_0003, 32'h0000_4008, 0, 0, 1, 0);
    chk("flush_valid", bus.ID_Valid, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("flush_count", bus.Count, 0);
    chk("flush_ready", bus.IF_Ready, 1);
    tick();

    // Delay-slot restart PC.
    step(1, 32'h1234_5678, 32'h0040_0104, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("bds_restart", bus.ID_RestartPC, 32'h0040_0100);
    chk("bds_flag", bus.ID_IsBDS, 1);
    tick();
`ifdef IFID_EXC_EN
    step(0, 0, 0, 0, 0, 1, 1);
    step(1, 32'hDEAD_BEEF, 32'h0040_0200, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("adif_nop", bus.ID_Instruction, 32'h0);
    chk("adif_flag", bus.ID_EXC_AdIF, 1);
    tick();
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r_ins = $urandom;
      r_pc  = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(0, 3) != 0, r_ins, r_pc, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
    end

    // Asynchronous reset between edges while occupied.
    step(1, 32'h4000_0001, 32'h0000_5000, 0, 0, 0, 1);
    step(1, 32'h4000_0002, 32'h0000_5004, 0, 0, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", bus.Count, 0);
    chk("arst_valid", bus.ID_Valid, 0);
    chk("arst_instr", bus.ID_Instruction, 32'h0);
    chk("arst_ready", bus.IF_Ready, 1);
    q.delete();
    #1;
    reset_n = 1'b1;
    step(1, 32'h5000_0001, 32'h0000_6000, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("arst_head", bus.ID_Instruction, 32'h5000_0001);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
